hash_bits_off_scheduler: RTL and testbench

Shares one `hash_bits_off_top` distance unit among `N_CORES` Skein hash cores. It grants pending hash-XOR results round-robin, loads the winner into the unit, and waits for the unit to finish counting. It then keeps a running minimum of bits-off, together with the winning core index and its input tag. It sits between the Skein core array and the host-visible result registers.

---
 rtl/hash_bits_off_scheduler.sv | 150 +++++++++++++++
 tb/tb_hash_bits_off_scheduler.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_bits_off_scheduler.sv
// hash_bits_off_scheduler: round-robin arbiter sharing one bits-off
// distance unit among hash cores, tracking the lowest result seen.
module hash_bits_off_scheduler #(
  parameter int N_CORES = 4,
  parameter int TAG_W = 64,
  parameter int CORE_W = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [N_CORES-1:0]        req_i,
  input  logic [N_CORES*1024-1:0]   hash_xor_i,
  input  logic [N_CORES*TAG_W-1:0]  tag_i,
  output logic [N_CORES-1:0]        grant_o,
  output logic [1023:0]             unit_hash_xor_o,
  output logic                      unit_new_hash_ready_o,
  input  logic [9:0]                unit_bits_off_i,
  input  logic                      unit_done_i,
  input  logic                      clear_best_i,
  output logic [9:0]                best_bits_off_o,
  output logic [CORE_W-1:0]         best_core_o,
  output logic [TAG_W-1:0]          best_tag_o,
  output logic                      best_update_o,
  output logic                      busy_o
);

  localparam logic [CORE_W:0]   NC    = (CORE_W+1)'(N_CORES);
  localparam logic [CORE_W-1:0] LAST  = CORE_W'(N_CORES-1);
  localparam logic [9:0]        WORST = 10'h3FF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ARM,
    WAIT,
    COMPARE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CORE_W-1:0]    rr_ptr;
  logic [CORE_W-1:0]    cur_core;
  logic [TAG_W-1:0]     cur_tag;
  logic [9:0]           cur_bits;

  logic [2*N_CORES-1:0] dbl;
  logic [N_CORES-1:0]   rot;
  logic [CORE_W-1:0]    off;
  logic [CORE_W:0]      sum;
  logic [CORE_W-1:0]    pick;
  logic                 any;
  logic [1023:0]        sel_hash;
  logic [TAG_W-1:0]     sel_tag;
  logic [9:0]           best_ref;
  logic                 take;

  // rotate requests so bit 0 is rr_ptr, then find first set
  always_comb begin
    dbl = {req_i, req_i};
    rot = N_CORES'(dbl >> rr_ptr);
    any = |req_i;
    off = '0;
    for (int i = N_CORES-1; i >= 0; i--) begin
      if (rot[i]) off = CORE_W'(i);
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= NC) sum = sum - NC;
    pick = sum[CORE_W-1:0];
  end

  always_comb begin
    sel_hash = '0;
    sel_tag  = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (pick == CORE_W'(i)) begin
        sel_hash = hash_xor_i[i*1024 +: 1024];
        sel_tag  = tag_i[i*TAG_W +: TAG_W];
      end
    end
  end

  // a clear during COMPARE lets the in-flight result stand alone
  always_comb begin
    best_ref = clear_best_i ? WORST : best_bits_off_o;
    take = (state == COMPARE) && (cur_bits < best_ref);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any) state_nxt = ISSUE;
      ISSUE:   state_nxt = ARM;
      ARM:     state_nxt = WAIT;
      WAIT:    if (unit_done_i) state_nxt = COMPARE;
      COMPARE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grant_o               <= '0;
      unit_hash_xor_o       <= '0;
      unit_new_hash_ready_o <= 1'b0;
      best_bits_off_o       <= WORST;
      best_core_o           <= '0;
      best_tag_o            <= '0;
      best_update_o         <= 1'b0;
      busy_o                <= 1'b0;
      rr_ptr                <= '0;
      cur_core              <= '0;
      cur_tag               <= '0;
      cur_bits              <= '0;
    end else begin
      grant_o               <= '0;
      unit_new_hash_ready_o <= 1'b0;
      best_update_o         <= 1'b0;
      busy_o                <= (state_nxt != IDLE);
      if (state == IDLE && any) begin
        unit_hash_xor_o       <= sel_hash;
        cur_tag               <= sel_tag;
        cur_core              <= pick;
        grant_o               <= N_CORES'(1) << pick;
        unit_new_hash_ready_o <= 1'b1;
      end
      if (state == ISSUE) begin
        rr_ptr <= (cur_core == LAST) ? '0 : cur_core + 1'b1;
      end
      if (state == WAIT && unit_done_i) begin
        cur_bits <= unit_bits_off_i;
      end
      if (take) begin
        best_bits_off_o <= cur_bits;
        best_core_o     <= cur_core;
        best_tag_o      <= cur_tag;
        best_update_o   <= 1'b1;
      end else if (clear_best_i) begin
        best_bits_off_o <= WORST;
        best_core_o     <= '0;
        best_tag_o      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hash_bits_off_scheduler.sv
// tb_hash_bits_off_scheduler: directed timing, table-driven min tracking
// and randomized round-robin traffic against a behavioural model.
module tb_hash_bits_off_scheduler;

  localparam int N  = 4;
  localparam int TW = 64;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_i;
  logic [N-1:0]      req_i;
  logic [N*1024-1:0] hash_xor_i;
  logic [N*TW-1:0]   tag_i;
  logic [N-1:0]      grant_o;
  logic [1023:0]     unit_hash_xor_o;
  logic              unit_new_hash_ready_o;
  logic [9:0]        unit_bits_off_i;
  logic              unit_done_i;
  logic              clear_best_i;
  logic [9:0]        best_bits_off_o;
  logic [CW-1:0]     best_core_o;
  logic [TW-1:0]     best_tag_o;
  logic              best_update_o;
  logic              busy_o;

  logic [1023:0] core_hash [N];
  logic [TW-1:0] core_tag  [N];

  always_comb begin
    hash_xor_i = '0;
    tag_i      = '0;
    for (int i = 0; i < N; i++) begin
      hash_xor_i[i*1024 +: 1024] = core_hash[i];
      tag_i[i*TW +: TW]          = core_tag[i];
    end
  end

  hash_bits_off_scheduler #(
    .N_CORES(N),
    .TAG_W(TW),
    .CORE_W(CW)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .req_i(req_i),
    .hash_xor_i(hash_xor_i),
    .tag_i(tag_i),
    .grant_o(grant_o),
    .unit_hash_xor_o(unit_hash_xor_o),
    .unit_new_hash_ready_o(unit_new_hash_ready_o),
    .unit_bits_off_i(unit_bits_off_i),
    .unit_done_i(unit_done_i),
    .clear_best_i(clear_best_i),
    .best_bits_off_o(best_bits_off_o),
    .best_core_o(best_core_o),
    .best_tag_o(best_tag_o),
    .best_update_o(best_update_o),
    .busy_o(busy_o)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         clr;
    int         core;
    logic [9:0] bits;
    logic [9:0] exp_bits;
    int         exp_core;
    int         exp_row;
    bit         exp_upd;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_hash(input string name, input logic [1023:0] act,
                          input logic [1023:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got low word %08h want %08h",
               name, act[31:0], exp[31:0]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [1023:0] rand_hash();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_core(input int c, input logic [63:0] tg);
    core_hash[c] = rand_hash();
    core_tag[c]  = tg;
  endtask

  task automatic do_reset();
    reset_i         = 1'b1;
    req_i           = '0;
    unit_done_i     = 1'b0;
    unit_bits_off_i = '0;
    clear_best_i    = 1'b0;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic wait_grant(input int c);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (grant_o != '0) break;
    end
    chk("grant", 64'(grant_o), 64'(1) << c);
  endtask

  // one full job; returns at the negedge of the cycle after COMPARE
  task automatic run_job(input int c, input logic [9:0] bits,
                         input logic [63:0] tg, input int lat,
                         input bit clr);
    set_core(c, tg);
    req_i[c] = 1'b1;
    wait_grant(c);
    chk_hash("job_hash", unit_hash_xor_o, core_hash[c]);
    chk("job_nhr", 64'(unit_new_hash_ready_o), 1);
    req_i[c] = 1'b0;
    repeat (2 + lat) tick();
    unit_bits_off_i = bits;
    unit_done_i     = 1'b1;
    tick();
    unit_done_i = 1'b0;
    chk("job_busy_cmp", 64'(busy_o), 1);
    chk("job_upd_early", 64'(best_update_o), 0);
    clear_best_i = clr;
    tick();
    clear_best_i = 1'b0;
  endtask

  int          mptr;
  logic [9:0]  mbest;
  int          mcore;
  logic [63:0] mtag;
  int          jcore;
  logic [63:0] jtag;
  logic [9:0]  jbits;
  int          cnt;
  bit          cnt_on;
  bit          prev_busy;
  int          stuck;
  int          ngrants;
  bit          skip [N];
  logic [63:0] last_tag;

  initial begin
    for (int i = 0; i < N; i++) begin
      core_hash[i] = '0;
      core_tag[i]  = '0;
    end
    do_reset();

    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_grant", 64'(grant_o), 0);
    chk("rst_nhr", 64'(unit_new_hash_ready_o), 0);
    chk("rst_upd", 64'(best_update_o), 0);
    chk("rst_best", 64'(best_bits_off_o), 64'h3FF);
    chk("rst_core", 64'(best_core_o), 0);
    chk("rst_tag", best_tag_o, 0);
    chk_hash("rst_hash", unit_hash_xor_o, '0);

    // single request with exact cycle positions
    set_core(2, 64'hC0DE_0002_0000_0001);
    req_i = 4'b0100;
    tick();
    chk("s_grant", 64'(grant_o), 4);
    chk("s_nhr", 64'(unit_new_hash_ready_o), 1);
    chk("s_busy_issue", 64'(busy_o), 1);
    chk_hash("s_hash", unit_hash_xor_o, core_hash[2]);
    req_i = '0;
    tick();
    chk("s_grant_arm", 64'(grant_o), 0);
    chk("s_nhr_arm", 64'(unit_new_hash_ready_o), 0);
    chk("s_busy_arm", 64'(busy_o), 1);
    tick();
    chk("s_busy_wait", 64'(busy_o), 1);
    tick();
    tick();
    unit_bits_off_i = 10'd400;
    unit_done_i     = 1'b1;
    tick();
    unit_done_i = 1'b0;
    chk("s_upd_cmp", 64'(best_update_o), 0);
    chk("s_busy_cmp", 64'(busy_o), 1);
    chk("s_best_cmp", 64'(best_bits_off_o), 64'h3FF);
    tick();
    chk("s_best", 64'(best_bits_off_o), 400);
    chk("s_core", 64'(best_core_o), 2);
    chk("s_tag", best_tag_o, 64'hC0DE_0002_0000_0001);
    chk("s_upd", 64'(best_update_o), 1);
    chk("s_busy_idle", 64'(busy_o), 0);
    tick();
    chk("s_upd_once", 64'(best_update_o), 0);
    chk("s_grant_once", 64'(grant_o), 0);

    // done held high across the whole job
    unit_bits_off_i = 10'd200;
    unit_done_i     = 1'b1;
    set_core(1, 64'h51A1E);
    req_i = 4'b0010;
    tick();
    chk("st_grant", 64'(grant_o), 2);
    req_i = '0;
    tick();
    chk("st_busy_arm", 64'(busy_o), 1);
    chk("st_upd_arm", 64'(best_update_o), 0);
    tick();
    chk("st_busy_wait", 64'(busy_o), 1);
    tick();
    chk("st_busy_cmp", 64'(busy_o), 1);
    chk("st_upd_cmp", 64'(best_update_o), 0);
    tick();
    chk("st_busy_idle", 64'(busy_o), 0);
    chk("st_upd", 64'(best_update_o), 1);
    chk("st_best", 64'(best_bits_off_o), 200);
    chk("st_core", 64'(best_core_o), 1);
    unit_done_i = 1'b0;

    // min tracking table
    tbl[0] = '{1'b1, 0, 10'd500,  10'd500,  0, 0,  1'b1};
    tbl[1] = '{1'b0, 1, 10'd300,  10'd300,  1, 1,  1'b1};
    tbl[2] = '{1'b0, 2, 10'd300,  10'd300,  1, 1,  1'b0};
    tbl[3] = '{1'b0, 3, 10'd700,  10'd300,  1, 1,  1'b0};
    tbl[4] = '{1'b0, 0, 10'h3FF,  10'd300,  1, 1,  1'b0};
    tbl[5] = '{1'b1, 2, 10'h3FF,  10'h3FF,  0, -1, 1'b0};
    tbl[6] = '{1'b0, 1, 10'd0,    10'd0,    1, 6,  1'b1};
    tbl[7] = '{1'b0, 3, 10'd0,    10'd0,    1, 6,  1'b0};
    tbl[8] = '{1'b0, 2, 10'd1,    10'd0,    1, 6,  1'b0};
    for (int r = 0; r < 9; r++) begin
      logic [63:0] tg;
      logic [63:0] etg;
      tg  = 64'hA5A5_0000_0000_0000 | 64'(r);
      etg = (tbl[r].exp_row < 0) ? 64'h0
          : (64'hA5A5_0000_0000_0000 | 64'(tbl[r].exp_row));
      if (tbl[r].clr) begin
        clear_best_i = 1'b1;
        tick();
        clear_best_i = 1'b0;
        chk("t_clr_best", 64'(best_bits_off_o), 64'h3FF);
        chk("t_clr_tag", best_tag_o, 0);
      end
      run_job(tbl[r].core, tbl[r].bits, tg, r % 3, 1'b0);
      chk("t_best", 64'(best_bits_off_o), 64'(tbl[r].exp_bits));
      chk("t_core", 64'(best_core_o), 64'(tbl[r].exp_core));
      chk("t_tag", best_tag_o, etg);
      chk("t_upd", 64'(best_update_o), 64'(tbl[r].exp_upd));
      chk("t_busy", 64'(busy_o), 0);
    end

    // clear during COMPARE
    clear_best_i = 1'b1;
    tick();
    clear_best_i = 1'b0;
    run_job(0, 10'd100, 64'hB00, 1, 1'b0);
    chk("c_best100", 64'(best_bits_off_o), 100);
    run_job(1, 10'd600, 64'hB01, 0, 1'b1);
    chk("c_best600", 64'(best_bits_off_o), 600);
    chk("c_core", 64'(best_core_o), 1);
    chk("c_tag", best_tag_o, 64'hB01);
    chk("c_upd", 64'(best_update_o), 1);
    run_job(3, 10'h3FF, 64'hB03, 2, 1'b1);
    chk("c_best_worst", 64'(best_bits_off_o), 64'h3FF);
    chk("c_core0", 64'(best_core_o), 0);
    chk("c_tag0", best_tag_o, 0);
    chk("c_upd0", 64'(best_update_o), 0);

    // round-robin fairness with all cores requesting
    do_reset();
    for (int c = 0; c < N; c++) set_core(c, {$urandom, $urandom});
    req_i    = 4'b1111;
    last_tag = '0;
    for (int i = 0; i < 5; i++) begin
      wait_grant(i % N);
      chk_hash("rr_hash", unit_hash_xor_o, core_hash[i % N]);
      last_tag = core_tag[i % N];
      set_core(i % N, {$urandom, $urandom});
      tick();
      tick();
      unit_bits_off_i = 10'(900 - i);
      unit_done_i     = 1'b1;
      tick();
      unit_done_i = 1'b0;
      tick();
    end
    req_i = '0;
    chk("rr_best", 64'(best_bits_off_o), 896);
    chk("rr_core", 64'(best_core_o), 0);
    chk("rr_tag", best_tag_o, last_tag);

    // reset in WAIT drops the job and rr_ptr
    set_core(2, 64'hD2);
    req_i[2] = 1'b1;
    wait_grant(2);
    req_i = '0;
    tick();
    tick();
    reset_i = 1'b1;
    tick();
    chk("r_busy", 64'(busy_o), 0);
    chk("r_best", 64'(best_bits_off_o), 64'h3FF);
    chk("r_core", 64'(best_core_o), 0);
    chk("r_tag", best_tag_o, 0);
    chk("r_grant", 64'(grant_o), 0);
    chk_hash("r_hash", unit_hash_xor_o, '0);
    reset_i         = 1'b0;
    unit_bits_off_i = 10'd5;
    unit_done_i     = 1'b1;
    repeat (4) tick();
    chk("r_late_busy", 64'(busy_o), 0);
    chk("r_late_best", 64'(best_bits_off_o), 64'h3FF);
    chk("r_late_upd", 64'(best_update_o), 0);
    unit_done_i = 1'b0;
    set_core(1, 64'hE1);
    set_core(3, 64'hE3);
    req_i = 4'b1010;
    wait_grant(1);
    req_i = '0;
    tick();
    tick();
    unit_bits_off_i = 10'd50;
    unit_done_i     = 1'b1;
    tick();
    unit_done_i = 1'b0;
    tick();
    chk("r_after_best", 64'(best_bits_off_o), 50);
    chk("r_after_core", 64'(best_core_o), 1);

    // randomized traffic against the model
    do_reset();
    mptr      = 0;
    mbest     = 10'h3FF;
    mcore     = 0;
    mtag      = '0;
    jcore     = 0;
    jtag      = '0;
    jbits     = '0;
    cnt       = 0;
    cnt_on    = 1'b0;
    prev_busy = 1'b0;
    stuck     = 0;
    ngrants   = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      clear_best_i = 1'b0;
      for (int c = 0; c < N; c++) skip[c] = 1'b0;
      if (grant_o != '0) begin
        int e;
        e = -1;
        for (int k = 0; k < N; k++) begin
          if (e < 0 && req_i[(mptr + k) % N]) e = (mptr + k) % N;
        end
        if (e < 0) e = 0;
        chk("rnd_grant", 64'(grant_o), 64'(1) << e);
        chk("rnd_nhr", 64'(unit_new_hash_ready_o), 1);
        chk_hash("rnd_hash", unit_hash_xor_o, core_hash[e]);
        jcore = e;
        jtag  = core_tag[e];
        jbits = ($urandom_range(0, 7) == 0) ? 10'h3FF
              : 10'($urandom_range(0, 1023));
        mptr        = (e + 1) % N;
        req_i[e]    = 1'b0;
        skip[e]     = 1'b1;
        unit_done_i = 1'b0;
        cnt         = $urandom_range(0, 5);
        cnt_on      = 1'b1;
        ngrants++;
      end else if (cnt_on) begin
        if (cnt == 0) begin
          unit_done_i     = 1'b1;
          unit_bits_off_i = jbits;
          cnt_on          = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (prev_busy && !busy_o) begin
        bit eu;
        eu = (jbits < mbest);
        if (eu) begin
          mbest = jbits;
          mcore = jcore;
          mtag  = jtag;
        end
        chk("rnd_best", 64'(best_bits_off_o), 64'(mbest));
        chk("rnd_core", 64'(best_core_o), 64'(mcore));
        chk("rnd_tag", best_tag_o, mtag);
        chk("rnd_upd", 64'(best_update_o), 64'(eu));
      end
      prev_busy = busy_o;
      if (busy_o) stuck++;
      else        stuck = 0;
      if (stuck > 60) begin
        chk("rnd_watchdog", 64'(stuck), 0);
        break;
      end
      if (cyc % 250 == 0 && !busy_o) begin
        clear_best_i = 1'b1;
        mbest = 10'h3FF;
        mcore = 0;
        mtag  = '0;
      end
      for (int c = 0; c < N; c++) begin
        if (!req_i[c] && !skip[c] && $urandom_range(0, 3) == 0) begin
          set_core(c, {$urandom, $urandom});
          req_i[c] = 1'b1;
        end
      end
    end
    req_i        = '0;
    clear_best_i = 1'b0;
    chk("rnd_grants_seen", 64'(ngrants > 100), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
